// File: rtl/merger_output_writer.sv
// Write-back stage behind the 16-record merger root: tuple FIFO plus beat serializer with linear addressing.
// Optional stall-cycle counter port o_stall_cycles is enabled by defining MERGER_OUT_PERF_CNT_EN.
module merger_output_writer #(
    parameter int DATA_WIDTH  = 128,
    parameter int OUT_RECORDS = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic [16*DATA_WIDTH-1:0]          i_data,
    input  logic                              i_write,
    output logic                              o_ready,
    input  logic                              i_start,
    input  logic [ADDR_WIDTH-1:0]             i_base_addr,
    input  logic [31:0]                       i_num_beats,
    output logic                              o_wr_valid,
    output logic [ADDR_WIDTH-1:0]             o_wr_addr,
    output logic [OUT_RECORDS*DATA_WIDTH-1:0] o_wr_data,
    input  logic                              i_wr_ready,
    output logic                              o_done,
    output logic                              o_overflow
`ifdef MERGER_OUT_PERF_CNT_EN
    ,
    output logic [31:0]                       o_stall_cycles
`endif
);

    localparam int TUPLE_W = 16 * DATA_WIDTH;
    localparam int BEAT_W  = OUT_RECORDS * DATA_WIDTH;
    localparam int BEATS   = 16 / OUT_RECORDS;
    localparam int BI_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = PTR_W + 1;

    localparam logic [BI_W-1:0]       BI_LAST   = BI_W'(BEATS - 1);
    localparam logic [CNT_W-1:0]      CNT_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(BEAT_W / 8);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [TUPLE_W-1:0]    r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [CNT_W-1:0]      w_count_next;
    logic                  r_ready;
    logic                  r_overflow;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_remaining;
    logic [BI_W-1:0]       r_bi;

    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic               w_valid;
    logic               w_hs;
    logic               w_last;
    logic               w_start;
    logic [TUPLE_W-1:0] w_head;

    assign w_full  = (r_count == CNT_FULL);
    assign w_push  = i_write & ~w_full;
    assign w_valid = (r_state == S_RUN) & (r_count != '0);
    assign w_hs    = w_valid & i_wr_ready;
    assign w_last  = (r_remaining == 32'd1);
    // The final beat of a run retires the head even when it is only partly sent.
    assign w_pop   = w_hs & ((r_bi == BI_LAST) | w_last);
    assign w_start = i_start & (r_state != S_RUN);
    assign w_head  = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    w_state_next = (i_num_beats == 32'd0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_hs && w_last) begin
                    w_state_next = S_DONE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_ready    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (i_write && w_full) begin
                r_overflow <= 1'b1;
            end
            r_count <= w_count_next;
            r_ready <= (w_count_next < CNT_FULL);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_bi        <= '0;
        end else if (w_start) begin
            r_addr      <= i_base_addr;
            r_remaining <= i_num_beats;
            r_bi        <= '0;
        end else if (w_hs) begin
            r_addr      <= r_addr + ADDR_STEP;
            r_remaining <= r_remaining - 32'd1;
            r_bi        <= w_pop ? '0 : r_bi + BI_W'(1);
        end
    end

`ifdef MERGER_OUT_PERF_CNT_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cycles <= '0;
        end else if (w_start) begin
            r_stall_cycles <= '0;
        end else if (w_valid && !i_wr_ready && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign o_stall_cycles = r_stall_cycles;
`endif

    assign o_ready    = r_ready;
    assign o_overflow = r_overflow;
    assign o_wr_valid = w_valid;
    assign o_wr_addr  = r_addr;
    assign o_wr_data  = w_head[int'(r_bi)*BEAT_W +: BEAT_W];
    assign o_done     = (r_state == S_DONE);

endmodule

// File: tb/tb_merger_output_writer.sv
// Scoreboard bench for merger_output_writer: directed runs, expected beats queued at start, monitor checks handshakes.
module tb_merger_output_writer;

    localparam int DW     = 128;
    localparam int OR     = 4;
    localparam int AW     = 32;
    localparam int FD     = 2;
    localparam int OW     = OR * DW;
    localparam int BEATS  = 16 / OR;
    localparam int STEP   = OW / 8;

    typedef struct {
        logic [AW-1:0] addr;
        logic [OW-1:0] data;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [16*DW-1:0]  i_data = '0;
    logic              i_write = 1'b0;
    logic              o_ready;
    logic              i_start = 1'b0;
    logic [AW-1:0]     i_base_addr = '0;
    logic [31:0]       i_num_beats = '0;
    logic              o_wr_valid;
    logic [AW-1:0]     o_wr_addr;
    logic [OW-1:0]     o_wr_data;
    logic              i_wr_ready = 1'b1;
    logic              o_done;
    logic              o_overflow;
`ifdef MERGER_OUT_PERF_CNT_EN
    logic [31:0]       o_stall_cycles;
`endif

    merger_output_writer #(
        .DATA_WIDTH (DW),
        .OUT_RECORDS(OR),
        .ADDR_WIDTH (AW),
        .FIFO_DEPTH (FD)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_data     (i_data),
        .i_write    (i_write),
        .o_ready    (o_ready),
        .i_start    (i_start),
        .i_base_addr(i_base_addr),
        .i_num_beats(i_num_beats),
        .o_wr_valid (o_wr_valid),
        .o_wr_addr  (o_wr_addr),
        .o_wr_data  (o_wr_data),
        .i_wr_ready (i_wr_ready),
        .o_done     (o_done),
        .o_overflow (o_overflow)
`ifdef MERGER_OUT_PERF_CNT_EN
        ,
        .o_stall_cycles(o_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int    total = 0;
    int    bad   = 0;
    beat_t sb_q[$];
    logic  [AW-1:0] exp_addr;

    task automatic chk(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rec(input int n);
        return {32'hCAFE_0000 | 32'(n), 32'h1234_5678 ^ 32'(n), 32'(n * 3), 32'(n)};
    endfunction

    function automatic logic [16*DW-1:0] tuple(input int t);
        logic [16*DW-1:0] v;
        v = '0;
        for (int k = 0; k < 16; k++) v[k*DW +: DW] = rec(t * 16 + k);
        return v;
    endfunction

    // Queue n beats of tuple t starting at beat index 0, advancing exp_addr.
    task automatic expect_beats(input int t, input int n);
        beat_t b;
        for (int j = 0; j < n; j++) begin
            b.addr = exp_addr;
            b.data = '0;
            for (int r = 0; r < OR; r++) b.data[r*DW +: DW] = rec(t * 16 + j * OR + r);
            sb_q.push_back(b);
            exp_addr = exp_addr + AW'(STEP);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int t);
        i_data  = tuple(t);
        i_write = 1'b1;
        tick();
        i_write = 1'b0;
    endtask

    task automatic start(input logic [AW-1:0] base, input int n);
        i_base_addr = base;
        i_num_beats = 32'(n);
        exp_addr    = base;
        i_start     = 1'b1;
        tick();
        i_start     = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!o_done && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("done_reached", OW'(o_done), OW'(1));
    endtask

    // Monitor: compare every accepted beat against the queue; verify stability across stalls.
    logic          hold_v = 1'b0;
    logic [AW-1:0] hold_addr;
    logic [OW-1:0] hold_data;
    beat_t         got;

    always @(negedge clk) begin
        if (rst_n) begin
            if (hold_v && o_wr_valid) begin
                chk("stall_addr_stable", OW'(o_wr_addr), OW'(hold_addr));
                chk("stall_data_stable", o_wr_data, hold_data);
            end
            hold_v = 1'b0;
            if (o_wr_valid && i_wr_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_beat_valid", OW'(o_wr_valid), OW'(0));
                end else begin
                    got = sb_q.pop_front();
                    chk("beat_addr", OW'(o_wr_addr), OW'(got.addr));
                    chk("beat_data", o_wr_data, got.data);
                end
            end else if (o_wr_valid) begin
                hold_v    = 1'b1;
                hold_addr = o_wr_addr;
                hold_data = o_wr_data;
            end
        end
    end

    int cyc;

    initial begin
        repeat (2) @(posedge clk);
        #2;
        chk("rst_ready", OW'(o_ready), OW'(1));
        chk("rst_valid", OW'(o_wr_valid), OW'(0));
        chk("rst_addr", OW'(o_wr_addr), OW'(0));
        chk("rst_data", o_wr_data, '0);
        chk("rst_done", OW'(o_done), OW'(0));
        chk("rst_overflow", OW'(o_overflow), OW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Two tuples, 8 beats back to back.
        push(0);
        push(1);
        start(32'h0000_1000, 8);
        expect_beats(0, BEATS);
        expect_beats(1, BEATS);
        wait_done(cyc);
        chk("run8_cycles", OW'(cyc), OW'(8));
        chk("run8_valid_low", OW'(o_wr_valid), OW'(0));

        // Overflow: third tuple dropped while full.
        push(2);
        chk("one_entry_ready", OW'(o_ready), OW'(1));
        push(3);
        chk("full_ready_low", OW'(o_ready), OW'(0));
        push(4);
        chk("overflow_set", OW'(o_overflow), OW'(1));
        chk("full_ready_still_low", OW'(o_ready), OW'(0));
        chk("done_no_valid", OW'(o_wr_valid), OW'(0));
        start(32'h0000_3000, 8);
        chk("done_falls", OW'(o_done), OW'(0));
        expect_beats(2, BEATS);
        expect_beats(3, BEATS);
        wait_done(cyc);
        chk("ovf_cycles", OW'(cyc), OW'(8));
        chk("ready_after_drain", OW'(o_ready), OW'(1));

        // Alternating back-pressure.
        push(5);
        i_wr_ready = 1'b1;
        start(32'h0000_4000, 4);
        expect_beats(5, BEATS);
        cyc = 0;
        while (!o_done && cyc < 50) begin
            tick();
            i_wr_ready = ~i_wr_ready;
            cyc++;
        end
        i_wr_ready = 1'b1;
        chk("stall_run_done", OW'(o_done), OW'(1));
        chk("stall_run_cycles", OW'(cyc), OW'(7));
`ifdef MERGER_OUT_PERF_CNT_EN
        chk("stall_cycles", OW'(o_stall_cycles), OW'(3));
`endif

        // Six beats across two tuples; second tuple retired early.
        push(6);
        push(7);
        start(32'h0000_5000, 6);
        expect_beats(6, BEATS);
        expect_beats(7, 2);
        wait_done(cyc);
        chk("run6_cycles", OW'(cyc), OW'(6));
        chk("run6_ready", OW'(o_ready), OW'(1));
        chk("run6_valid_low", OW'(o_wr_valid), OW'(0));

        // Zero-beat run with data waiting.
        push(8);
        start(32'h0000_6000, 0);
        chk("zero_done", OW'(o_done), OW'(1));
        chk("zero_valid", OW'(o_wr_valid), OW'(0));
        repeat (3) tick();
        chk("zero_valid_later", OW'(o_wr_valid), OW'(0));

        // Address wrap; the waiting tuple is the one emitted.
        start(32'hFFFF_FFC0, 2);
        expect_beats(8, 2);
        wait_done(cyc);
        chk("wrap_cycles", OW'(cyc), OW'(2));
        chk("wrap_addr_after", OW'(o_wr_addr), OW'(32'h0000_0040));

        // Asynchronous reset in the middle of a stalled run.
        push(9);
        i_wr_ready = 1'b0;
        start(32'h0000_7000, 4);
        tick();
        tick();
        chk("midrun_valid", OW'(o_wr_valid), OW'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ready", OW'(o_ready), OW'(1));
        chk("arst_valid", OW'(o_wr_valid), OW'(0));
        chk("arst_addr", OW'(o_wr_addr), OW'(0));
        chk("arst_data", o_wr_data, '0);
        chk("arst_done", OW'(o_done), OW'(0));
        chk("arst_overflow", OW'(o_overflow), OW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        i_wr_ready = 1'b1;
        repeat (3) tick();
        chk("post_rst_valid", OW'(o_wr_valid), OW'(0));
        chk("scoreboard_empty", OW'(sb_q.size()), OW'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
